// File: rtl/dlx_alu_seq.sv
// rtl/dlx_alu_seq.sv - parametrised DLX execute-stage ALU with iterative multiply/divide
//
// Purpose: single-cycle ALU operations plus W-cycle shift-add multiply and
// restoring divide, under a busy/valid handshake used to stall the pipeline.
// Optional feature macro: DLX_ALU_DIV_EN (compiles the divider for opcodes 18/19;
// without it those opcodes act as invalid single-cycle opcodes).
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   EX     in   start strobe, sampled only while busy=0
//   I      in   5-bit opcode
//   op1    in   W-bit first operand
//   op2    in   W-bit second operand
//   res1   out  registered W-bit result
//   carry  out  registered carry/overflow flag
//   z      out  registered zero flag
//   busy   out  multi-cycle operation in progress
//   valid  out  one-cycle pulse: res1/carry/z were updated on the previous edge
module dlx_alu_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         EX,
  input  logic [4:0]   I,
  input  logic [W-1:0] op1,
  input  logic [W-1:0] op2,
  output logic [W-1:0] res1,
  output logic         carry,
  output logic         z,
  output logic         busy,
  output logic         valid
);

  localparam int SW = $clog2(W);
  localparam int CW = SW + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [4:0]     r_op;
  logic [W-1:0]   r_op2;
  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_res;
  logic           r_carry;
  logic           r_z;
  logic           r_busy;
  logic           r_valid;

  logic           w_start;
  logic           w_single;
  logic           w_done;
  logic           w_is_multi;
  logic [SW-1:0]  w_sa;
  logic [W:0]     w_add;
  logic [W:0]     w_sub;
  logic [W-1:0]   w_res;
  logic           w_carry;
  logic [W:0]     w_msum;
  logic [2*W-1:0] w_acc_nxt;
  logic [W-1:0]   w_mres;
  logic           w_mcarry;

`ifdef DLX_ALU_DIV_EN
  logic [W-1:0]   r_rem;
  logic [W:0]     w_dshift;
  logic [W:0]     w_ddiff;
  logic           w_qbit;
  logic [W-1:0]   w_rem_nxt;
`endif

  assign res1  = r_res;
  assign carry = r_carry;
  assign z     = r_z;
  assign busy  = r_busy;
  assign valid = r_valid;

  assign w_sa  = op2[SW-1:0];
  assign w_add = {1'b0, op1} + {1'b0, op2};
  assign w_sub = {1'b0, op1} - {1'b0, op2};

`ifdef DLX_ALU_DIV_EN
  assign w_is_multi = (I == 5'd16) || (I == 5'd17) || (I == 5'd18) || (I == 5'd19);
`else
  assign w_is_multi = (I == 5'd16) || (I == 5'd17);
`endif

  // Single-cycle operation mux; opcodes without a case (including disabled
  // divide opcodes) yield res=0, carry=0, hence z=1.
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    case (I)
      5'd0:  w_res = op2 << (W/2);
      5'd1:  begin w_res = w_add[W-1:0]; w_carry = w_add[W]; end
      5'd2:  begin w_res = w_sub[W-1:0]; w_carry = w_sub[W]; end
      5'd3:  w_res = op1 & op2;
      5'd4:  w_res = op1 | op2;
      5'd5:  w_res = op1 ^ op2;
      5'd6:  w_res = op1 << w_sa;
      5'd7:  w_res = op1 >> w_sa;
      5'd8:  w_res = (op1 == '0) ? op2 : '0;
      5'd9:  w_res = (op1 != '0) ? op2 : '0;
      5'd10: w_res = (op1 == op2) ? '1 : '0;
      5'd11: w_res = (op1 <= op2) ? '1 : '0;
      5'd12: w_res = (op1 <  op2) ? '1 : '0;
      5'd13: w_res = (op1 != op2) ? '1 : '0;
      5'd14: w_res = $signed(op1) >>> w_sa;
      5'd15: w_res = op1 + W'(4);
      5'd20: w_res = ($signed(op1) <  $signed(op2)) ? '1 : '0;
      5'd21: w_res = ($signed(op1) <= $signed(op2)) ? '1 : '0;
      default: ;
    endcase
  end

  // Iterative step. Multiply: low half of r_acc holds the multiplier and is
  // shifted out LSB first while the product grows in from the top.
  // Divide: low half holds the dividend, shifted out MSB first while quotient
  // bits shift in at the bottom; divisor 0 naturally gives all-ones / op1.
  always_comb begin
    w_msum    = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_op2} : '0);
    w_acc_nxt = {w_msum, r_acc[W-1:1]};
`ifdef DLX_ALU_DIV_EN
    w_dshift  = {r_rem, r_acc[W-1]};
    w_ddiff   = w_dshift - {1'b0, r_op2};
    w_qbit    = ~w_ddiff[W];
    w_rem_nxt = w_qbit ? w_ddiff[W-1:0] : w_dshift[W-1:0];
    if ((r_op == 5'd18) || (r_op == 5'd19)) begin
      w_acc_nxt = {r_acc[2*W-1:W], r_acc[W-2:0], w_qbit};
    end
`endif
  end

  // Final multi-cycle result, taken from the value the last step produces.
  always_comb begin
    w_mres   = '0;
    w_mcarry = 1'b0;
    case (r_op)
      5'd16: begin w_mres = w_acc_nxt[W-1:0]; w_mcarry = |w_acc_nxt[2*W-1:W]; end
      5'd17: w_mres = w_acc_nxt[2*W-1:W];
`ifdef DLX_ALU_DIV_EN
      5'd18: w_mres = w_acc_nxt[W-1:0];
      5'd19: w_mres = w_rem_nxt;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_single    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (EX) begin
          if (w_is_multi) begin
            w_start     = 1'b1;
            w_state_nxt = S_RUN;
          end else begin
            w_single    = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (r_cnt == CW'(1)) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_op    <= '0;
      r_op2   <= '0;
      r_acc   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_z     <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
`ifdef DLX_ALU_DIV_EN
      r_rem   <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      if (w_single) begin
        r_res   <= w_res;
        r_carry <= w_carry;
        r_z     <= (w_res == '0);
        r_valid <= 1'b1;
      end
      if (w_start) begin
        r_op    <= I;
        r_op2   <= op2;
        r_acc   <= {{W{1'b0}}, op1};
        r_cnt   <= CW'(W);
        r_busy  <= 1'b1;
`ifdef DLX_ALU_DIV_EN
        r_rem   <= '0;
`endif
      end
      if (r_state == S_RUN) begin
        r_cnt <= r_cnt - CW'(1);
        r_acc <= w_acc_nxt;
`ifdef DLX_ALU_DIV_EN
        r_rem <= w_rem_nxt;
`endif
      end
      if (w_done) begin
        r_res   <= w_mres;
        r_carry <= w_mcarry;
        r_z     <= (w_mres == '0);
        r_busy  <= 1'b0;
        r_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dlx_alu_seq.sv
// tb/tb_dlx_alu_seq.sv - self-checking bench for dlx_alu_seq against a behavioural model
module tb_dlx_alu_seq;

  localparam int W = 32;
`ifdef DLX_ALU_DIV_EN
  localparam bit DIV = 1'b1;
`else
  localparam bit DIV = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         EX  = 1'b0;
  logic [4:0]   I   = '0;
  logic [W-1:0] op1 = '0;
  logic [W-1:0] op2 = '0;
  logic [W-1:0] res1;
  logic         carry, z, busy, valid;

  logic         ex16 = 1'b0;
  logic [4:0]   i16  = '0;
  logic [15:0]  a16  = '0;
  logic [15:0]  b16  = '0;
  logic [15:0]  res16;
  logic         c16, z16, busy16, valid16;

  int n_vec = 0;
  int n_err = 0;

  dlx_alu_seq #(.W(W)) u_dut (
    .clk(clk), .rst(rst), .EX(EX), .I(I), .op1(op1), .op2(op2),
    .res1(res1), .carry(carry), .z(z), .busy(busy), .valid(valid)
  );

  dlx_alu_seq #(.W(16)) u_dut16 (
    .clk(clk), .rst(rst), .EX(ex16), .I(i16), .op1(a16), .op2(b16),
    .res1(res16), .carry(c16), .z(z16), .busy(busy16), .valid(valid16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the opcode table evaluated with plain arithmetic.
  function automatic void ref_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic c);
    logic [63:0] s;
    logic [63:0] p;
    int unsigned sa;
    sa = b % W;
    p  = 64'(a) * 64'(b);
    r  = '0;
    c  = 1'b0;
    case (op)
      5'd0:  r = b << (W/2);
      5'd1:  begin s = 64'(a) + 64'(b); r = s[W-1:0]; c = (s >= (64'd1 << W)); end
      5'd2:  begin r = a - b; c = (a < b); end
      5'd3:  r = a & b;
      5'd4:  r = a | b;
      5'd5:  r = a ^ b;
      5'd6:  r = a << sa;
      5'd7:  r = a >> sa;
      5'd8:  r = (a == 0) ? b : '0;
      5'd9:  r = (a != 0) ? b : '0;
      5'd10: r = (a == b) ? '1 : '0;
      5'd11: r = (a <= b) ? '1 : '0;
      5'd12: r = (a <  b) ? '1 : '0;
      5'd13: r = (a != b) ? '1 : '0;
      5'd14: r = W'($signed(a) >>> sa);
      5'd15: r = a + 4;
      5'd16: begin r = p[W-1:0]; c = (p[2*W-1:W] != 0); end
      5'd17: r = p[2*W-1:W];
      5'd18: if (DIV) r = (b == 0) ? '1 : a / b;
      5'd19: if (DIV) r = (b == 0) ? a : a % b;
      5'd20: r = ($signed(a) <  $signed(b)) ? '1 : '0;
      5'd21: r = ($signed(a) <= $signed(b)) ? '1 : '0;
      default: ;
    endcase
  endfunction

  function automatic bit is_multi(input logic [4:0] op);
    return (op == 5'd16) || (op == 5'd17) || (DIV && ((op == 5'd18) || (op == 5'd19)));
  endfunction

  // Timeline model: what the outputs must be after each rising edge.
  logic [W-1:0] m_res = '0, p_res = '0;
  logic         m_c = 1'b0, m_z = 1'b0, m_busy = 1'b0, m_valid = 1'b0, p_c = 1'b0;
  int           m_left = 0;

  always @(posedge clk or posedge rst) begin : model
    logic [W-1:0] r;
    logic         c;
    if (rst) begin
      m_res <= '0; m_c <= 1'b0; m_z <= 1'b0; m_busy <= 1'b0; m_valid <= 1'b0; m_left <= 0;
    end else begin
      m_valid <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0; m_valid <= 1'b1; m_res <= p_res; m_c <= p_c; m_z <= (p_res == 0);
        end
        m_left <= m_left - 1;
      end else if (EX) begin
        ref_op(I, op1, op2, r, c);
        if (is_multi(I)) begin
          m_busy <= 1'b1; m_left <= W; p_res <= r; p_c <= c;
        end else begin
          m_res <= r; m_c <= c; m_z <= (r == 0); m_valid <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_busy",  64'(busy),  64'(m_busy));
    chk("cmp_valid", 64'(valid), 64'(m_valid));
    chk("cmp_res",   64'(res1),  64'(m_res));
    chk("cmp_carry", 64'(carry), 64'(m_c));
    chk("cmp_z",     64'(z),     64'(m_z));
  end

  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    #2;
    EX = 1'b1; I = op; op1 = a; op2 = b;
    @(posedge clk);
    #2;
    EX = 1'b0; I = 5'($urandom); op1 = $urandom; op2 = $urandom;
  endtask

  task automatic wait_valid(output int nbusy, output bit seen);
    nbusy = 0;
    seen  = 1'b0;
    for (int i = 0; i < W + 5; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic run(input string nm, input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] er, input logic ec, input int eb);
    int nb;
    bit seen;
    issue(op, a, b);
    wait_valid(nb, seen);
    chk({nm, "_valid_seen"}, 64'(seen), 64'd1);
    chk({nm, "_res"},   64'(res1),  64'(er));
    chk({nm, "_carry"}, 64'(carry), 64'(ec));
    chk({nm, "_z"},     64'(z),     64'(er == 0));
    chk({nm, "_busy_cycles"}, 64'(nb), 64'(eb));
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return W'($urandom_range(0, 9));
      3: return {1'b1, {(W-1){1'b0}}};
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [4:0] pick_op();
    if ($urandom_range(0, 9) < 3) return 5'(16 + $urandom_range(0, 3));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin : main
    logic [W-1:0] r;
    logic         c;
    int           nb;
    bit           seen;
    logic [4:0]   t_op [3];
    logic [15:0]  t_res [3];

    // Model pinned to hand-computed values.
    ref_op(5'd1, 32'hFFFF_FFFF, 32'd1, r, c);
    chk("model_add", {31'd0, c, r}, {31'd0, 1'b1, 32'h0});
    ref_op(5'd16, 32'h1_0000, 32'h1_0000, r, c);
    chk("model_mulu", {31'd0, c, r}, {31'd0, 1'b1, 32'h0});
    ref_op(5'd14, 32'h8000_0000, 32'd31, r, c);
    chk("model_sra", 64'(r), 64'hFFFF_FFFF);

    repeat (3) @(negedge clk);
    chk("rst_res",   64'(res1),  64'd0);
    chk("rst_busy",  64'(busy),  64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_z",     64'(z),     64'd0);
    #2 rst = 1'b0;

    run("add_ovf", 5'd1, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 0);
    @(negedge clk);
    chk("add_valid_one_cycle", 64'(valid), 64'd0);
    run("sra", 5'd14, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 0);
    run("sll33", 5'd6, 32'd3, 32'd33, 32'd6, 1'b0, 0);
    run("mulu", 5'd16, 32'h1_0000, 32'h1_0000, 32'd0, 1'b1, W);
    run("mulhu", 5'd17, 32'h1_0000, 32'h1_0000, 32'd1, 1'b0, W);
    run("divu", 5'd18, 32'd100, 32'd7, DIV ? 32'd14 : 32'd0, 1'b0, DIV ? W : 0);
    run("remu", 5'd19, 32'd100, 32'd7, DIV ? 32'd2 : 32'd0, 1'b0, DIV ? W : 0);
    run("divu0", 5'd18, 32'd5, 32'd0, DIV ? 32'hFFFF_FFFF : 32'd0, 1'b0, DIV ? W : 0);
    run("remu0", 5'd19, 32'd5, 32'd0, DIV ? 32'd5 : 32'd0, 1'b0, DIV ? W : 0);

    // EX during RUN must be ignored, not queued.
    issue(5'd16, 32'd3, 32'd5);
    repeat (5) @(negedge clk);
    #2 EX = 1'b1; I = 5'd1; op1 = 32'd7; op2 = 32'd8;
    @(posedge clk);
    #2 EX = 1'b0;
    wait_valid(nb, seen);
    chk("midrun_seen", 64'(seen), 64'd1);
    chk("midrun_res", 64'(res1), 64'd15);
    @(negedge clk);
    chk("midrun_not_queued", 64'(valid), 64'd0);

    // Reset 10 cycles into a multiply aborts it.
    issue(5'd16, 32'h1234, 32'h5678);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_res",   64'(res1),  64'd0);
    chk("abort_busy",  64'(busy),  64'd0);
    chk("abort_valid", 64'(valid), 64'd0);
    chk("abort_carry", 64'(carry), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_valid", 64'(valid), 64'd0);
    end
    run("add_after_rst", 5'd1, 32'd2, 32'd3, 32'd5, 1'b0, 0);

    // W=16 instance: signed vs unsigned compare and an invalid opcode.
    t_op[0] = 5'd20; t_res[0] = 16'hFFFF;
    t_op[1] = 5'd12; t_res[1] = 16'h0000;
    t_op[2] = 5'd25; t_res[2] = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #2 ex16 = 1'b1; i16 = t_op[k]; a16 = 16'h8000; b16 = 16'h0001;
      @(negedge clk);
      chk("w16_res",   64'(res16),   64'(t_res[k]));
      chk("w16_z",     64'(z16),     64'(t_res[k] == 0));
      chk("w16_carry", 64'(c16),     64'd0);
      chk("w16_valid", 64'(valid16), 64'd1);
      chk("w16_busy",  64'(busy16),  64'd0);
      #2 ex16 = 1'b0;
    end

    // Random traffic; the compare process checks every cycle.
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      #2;
      EX  = ($urandom_range(0, 3) != 0);
      I   = pick_op();
      op1 = pick_val();
      op2 = pick_val();
      if (k % 500 == 250) begin
        rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end
    #2 EX = 1'b0;
    repeat (W + 5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
